trigger_sequencer: RTL and testbench

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

---
 rtl/trigger_sequencer_pkg.sv | 20 ++
 rtl/trigger_sequencer.sv | 161 ++++++++++++++++
 tb/tb_trigger_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_sequencer_pkg.sv
// Shared types and constants for the capture trigger sequencer.
// State encoding, trig_in bit positions and default window width.
package trigger_sequencer_pkg;

  localparam int ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int TRIG_CH1_RISE = 0;
  localparam int TRIG_CH1_FALL = 1;
  localparam int TRIG_CH2_RISE = 2;
  localparam int TRIG_CH2_FALL = 3;

endpackage

// File: rtl/trigger_sequencer.sv
// Capture-window trigger sequencer between the level-trigger stage and DMA.
// Ports: stream_clk/resetn, AXIS slave s_*, AXIS master m_*, trig_in/mask,
// sw_trigger, arm/abort, total_count/pre_count, state_o, status, trig_addr.
module trigger_sequencer #(
  parameter int ADDR_WIDTH = trigger_sequencer_pkg::ADDR_WIDTH
) (
  input  logic                  stream_clk,
  input  logic                  resetn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [31:0]           s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           m_tdata,
  output logic                  m_tlast,
  input  logic [3:0]            trig_in,
  input  logic [3:0]            trig_mask,
  input  logic                  sw_trigger,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] total_count,
  input  logic [ADDR_WIDTH-1:0] pre_count,
  output logic [2:0]            state_o,
  output logic                  done,
  output logic                  aborted,
  output logic                  cfg_error,
  output logic [ADDR_WIDTH-1:0] trig_addr
);

  import trigger_sequencer_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] tot_q;
  logic [ADDR_WIDTH-1:0] pre_q;
  logic [3:0]            mask_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] pre_left;
  logic [ADDR_WIDTH-1:0] post_left;
  logic                  sw_pend;

  logic active;
  logic accept;
  logic hit;
  logic single;
  logic cfg_bad;
  logic arm_ok;
  logic arm_bad;
  logic trig_fire;

  assign active = resetn &&
    (state == S_PRE || state == S_ARMED || state == S_POST);

  // Idle/done states swallow beats so upstream never stalls.
  assign s_tready = active ? m_tready : 1'b1;
  assign m_tvalid = active && s_tvalid;
  assign m_tdata  = s_tdata;
  assign accept   = s_tvalid && s_tready;
  assign state_o  = state;

  // A pending sw_trigger waits for the next accepted beat.
  assign hit     = (|(trig_in & mask_q)) || sw_trigger || sw_pend;
  assign single  = (tot_q - pre_q) == ONE;
  assign cfg_bad = (total_count == '0) || (pre_count >= total_count);

  always_ff @(posedge stream_clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    m_tlast   = 1'b0;
    arm_ok    = 1'b0;
    arm_bad   = 1'b0;
    trig_fire = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (arm && !abort) begin
          if (cfg_bad) begin
            arm_bad = 1'b1;
          end else begin
            arm_ok  = 1'b1;
            state_n = (pre_count == '0) ? S_ARMED : S_PRE;
          end
        end
      end
      S_PRE: begin
        if (abort)
          state_n = S_IDLE;
        else if (accept && pre_left == ONE)
          state_n = S_ARMED;
      end
      S_ARMED: begin
        m_tlast = resetn && !abort && s_tvalid && hit && single;
        if (abort) begin
          state_n = S_IDLE;
        end else if (accept && hit) begin
          trig_fire = 1'b1;
          state_n   = single ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        m_tlast = resetn && !abort && s_tvalid && post_left == ONE;
        if (abort)
          state_n = S_IDLE;
        else if (accept && post_left == ONE)
          state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge stream_clk) begin
    if (!resetn) begin
      tot_q     <= '0;
      pre_q     <= '0;
      mask_q    <= '0;
      addr      <= '0;
      pre_left  <= '0;
      post_left <= '0;
      sw_pend   <= 1'b0;
      trig_addr <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      sw_pend <= (state == S_ARMED) && (state_n == S_ARMED) &&
                 (sw_pend || sw_trigger);
      if (arm_ok) begin
        tot_q     <= total_count;
        pre_q     <= pre_count;
        mask_q    <= trig_mask;
        pre_left  <= pre_count;
        addr      <= '0;
        done      <= 1'b0;
        aborted   <= 1'b0;
        cfg_error <= 1'b0;
      end
      if (arm_bad)
        cfg_error <= 1'b1;
      if (active && accept)
        addr <= (addr == tot_q - ONE) ? '0 : addr + ONE;
      if (state == S_PRE && accept)
        pre_left <= pre_left - ONE;
      if (trig_fire) begin
        trig_addr <= addr;
        post_left <= tot_q - pre_q - ONE;
      end
      if (state == S_POST && accept)
        post_left <= post_left - ONE;
      if (state_n == S_DONE && state != S_DONE)
        done <= 1'b1;
      if (active && abort)
        aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer.
// Drives capture scenarios and checks status, addresses and tlast placement.
module tb_trigger_sequencer;

  logic        stream_clk = 1'b0;
  logic        resetn;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  trig_in;
  logic [3:0]  trig_mask;
  logic        sw_trigger;
  logic        arm;
  logic        abort;
  logic [15:0] total_count;
  logic [15:0] pre_count;
  logic [2:0]  state_o;
  logic        done;
  logic        aborted;
  logic        cfg_error;
  logic [15:0] trig_addr;

  trigger_sequencer dut (
    .stream_clk  (stream_clk),
    .resetn      (resetn),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .trig_in     (trig_in),
    .trig_mask   (trig_mask),
    .sw_trigger  (sw_trigger),
    .arm         (arm),
    .abort       (abort),
    .total_count (total_count),
    .pre_count   (pre_count),
    .state_o     (state_o),
    .done        (done),
    .aborted     (aborted),
    .cfg_error   (cfg_error),
    .trig_addr   (trig_addr)
  );

  always #5 stream_clk = ~stream_clk;

  int total = 0;
  int bad   = 0;

  int          nbeats = 0;
  int          nlast  = 0;
  int          last_at = 0;
  int          gaps   = 0;
  bit          have_prev = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge stream_clk) begin
    if (resetn && m_tvalid && m_tready) begin
      nbeats <= nbeats + 1;
      if (have_prev && m_tdata !== prev_data + 32'd1)
        gaps <= gaps + 1;
      prev_data <= m_tdata;
      have_prev <= 1'b1;
      if (m_tlast) begin
        nlast   <= nlast + 1;
        last_at <= nbeats + 1;
      end
    end
  end

  logic [31:0] seq = 32'd100;
  logic        beat_last;
  int          b0, l0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge stream_clk);
    #1;
  endtask

  task automatic pulse(input bit a, input bit ab, input bit sw);
    arm = a;
    abort = ab;
    sw_trigger = sw;
    step();
    arm = 1'b0;
    abort = 1'b0;
    sw_trigger = 1'b0;
  endtask

  task automatic setup(input int tot, input int pre, input logic [3:0] msk);
    total_count = 16'(tot);
    pre_count   = 16'(pre);
    trig_mask   = msk;
  endtask

  task automatic send(input logic [3:0] t, input bit rnd);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    s_tvalid = 1'b1;
    s_tdata  = seq;
    trig_in  = t;
    while (!ok && n < 64) begin
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      #4;
      ok = s_tready;
      beat_last = m_tlast;
      step();
      n++;
    end
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL send_timeout got=%0d exp=1", ok);
    end
    seq++;
    s_tvalid = 1'b0;
    trig_in  = '0;
  endtask

  task automatic mark();
    b0 = nbeats;
    l0 = nlast;
  endtask

  initial begin
    resetn = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = '0;
    m_tready = 1'b1;
    trig_in = '0;
    trig_mask = '0;
    sw_trigger = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    total_count = '0;
    pre_count = '0;
    beat_last = 1'b0;
    #2;
    chk("rst_tready", s_tready, 1);
    chk("rst_tvalid", m_tvalid, 0);
    step();
    step();
    s_tvalid = 1'b0;
    resetn = 1'b1;
    step();
    chk("rst_state", state_o, 0);
    chk("rst_flags", {done, aborted, cfg_error}, 0);
    chk("rst_taddr", trig_addr, 0);

    // bad config then total-pre=1 window
    setup(4, 4, 4'b0001);
    pulse(1, 0, 0);
    chk("cfg_err", cfg_error, 1);
    chk("cfg_state", state_o, 0);
    setup(5, 4, 4'b0001);
    pulse(1, 0, 0);
    chk("t3_state", state_o, 1);
    chk("t3_cfgclr", cfg_error, 0);
    mark();
    for (int i = 0; i < 4; i++) send(4'b0000, 0);
    chk("t3_armed", state_o, 2);
    send(4'b0001, 0);
    chk("t3_last", beat_last, 1);
    chk("t3_state2", state_o, 4);
    chk("t3_done", done, 1);
    chk("t3_taddr", trig_addr, 4);
    chk("t3_beats", nbeats - b0, 5);

    // discard in DONE
    s_tvalid = 1'b1;
    #1;
    chk("done_tvalid", m_tvalid, 0);
    chk("done_tready", s_tready, 1);
    s_tvalid = 1'b0;

    // total=8 pre=3, ch1_rising on beat 6
    setup(8, 3, 4'b0001);
    pulse(1, 0, 0);
    chk("t1_pre", state_o, 1);
    chk("t1_doneclr", done, 0);
    mark();
    for (int i = 0; i < 3; i++) send(4'b0000, 0);
    chk("t1_armed", state_o, 2);
    send(4'b0000, 0);
    send(4'b0000, 0);
    send(4'b0001, 0);
    chk("t1_post", state_o, 3);
    chk("t1_taddr", trig_addr, 5);
    for (int i = 0; i < 4; i++) send(4'b0000, 0);
    chk("t1_done", done, 1);
    chk("t1_beats", nbeats - b0, 10);
    chk("t1_nlast", nlast - l0, 1);
    chk("t1_lastat", last_at - b0, 10);

    // pre=0, sw_trigger in an idle cycle
    setup(4, 0, 4'b0000);
    pulse(1, 0, 0);
    chk("t2_armed", state_o, 2);
    pulse(0, 0, 1);
    chk("t2_pend", state_o, 2);
    mark();
    send(4'b0000, 0);
    chk("t2_post", state_o, 3);
    chk("t2_taddr", trig_addr, 0);
    for (int i = 0; i < 3; i++) send(4'b0000, 0);
    chk("t2_state", state_o, 4);
    chk("t2_lastat", last_at - b0, 4);
    chk("t2_nlast", nlast - l0, 1);

    // flags during PRE ignored, masked flag ignored
    setup(6, 2, 4'b0100);
    pulse(1, 0, 0);
    mark();
    send(4'b0100, 0);
    send(4'b0100, 0);
    chk("t4_armed", state_o, 2);
    send(4'b0010, 0);
    chk("t4_masked", state_o, 2);
    send(4'b0100, 0);
    chk("t4_post", state_o, 3);
    chk("t4_taddr", trig_addr, 3);
    for (int i = 0; i < 3; i++) send(4'b0000, 0);
    chk("t4_lastat", last_at - b0, 7);
    chk("t4_done", done, 1);

    // address wrap, random backpressure in POST
    setup(8, 1, 4'b0001);
    pulse(1, 0, 0);
    mark();
    for (int i = 0; i < 10; i++) send(4'b0000, 0);
    send(4'b0001, 0);
    chk("t5_taddr", trig_addr, 2);
    for (int i = 0; i < 6; i++) send(4'b0000, 1);
    m_tready = 1'b1;
    chk("t5_beats", nbeats - b0, 17);
    chk("t5_nlast", nlast - l0, 1);
    chk("t5_lastat", last_at - b0, 17);
    chk("t5_done", done, 1);

    // abort while ARMED, then arm+abort, then normal capture
    setup(4, 0, 4'b0001);
    pulse(1, 0, 0);
    mark();
    send(4'b0000, 0);
    s_tvalid = 1'b1;
    s_tdata = seq;
    trig_in = 4'b0001;
    abort = 1'b1;
    #1;
    chk("t6_pass", m_tvalid, 1);
    chk("t6_nolast", m_tlast, 0);
    step();
    seq++;
    abort = 1'b0;
    s_tvalid = 1'b0;
    trig_in = '0;
    chk("t6_idle", state_o, 0);
    chk("t6_aborted", aborted, 1);
    chk("t6_beats", nbeats - b0, 2);
    chk("t6_nlast", nlast - l0, 0);
    setup(4, 1, 4'b0001);
    pulse(1, 1, 0);
    chk("t6_both", state_o, 0);
    chk("t6_abst", aborted, 1);
    pulse(1, 0, 0);
    chk("t6_rearm", state_o, 1);
    chk("t6_abclr", aborted, 0);
    mark();
    send(4'b0000, 0);
    send(4'b0001, 0);
    chk("t6_taddr", trig_addr, 1);
    send(4'b0000, 0);
    send(4'b0000, 0);
    chk("t6_done", done, 1);
    chk("t6_lastat", last_at - b0, 4);
    chk("gaps", gaps, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
